// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock frequency monitor: FSM encoding,
// pipeline depths and the acceptance-window helper.
package clk_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_GATE = 2'd2
  } state_t;

  localparam int FILL_CYCLES = 2;
  localparam int SYNC_STAGES = 2;

  function automatic logic in_window(input logic [31:0] value,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (value >= lo) && (value <= hi);
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by an edge register; produces rise and
// any-edge strobes for an asynchronous input in the iCLK domain.
module sync_edge_detect
  import clk_mon_pkg::*;
(
  input  logic iCLK,
  input  logic iRSTb,
  input  logic iIN,
  output logic oRISE,
  output logic oANY
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge iCLK or negedge iRSTb) begin
    if (!iRSTb) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], iIN};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign oRISE = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign oANY  = r_sync[SYNC_STAGES-1] ^ r_prev;

endmodule

// File: rtl/clk_freq_monitor.sv
// Counts rising edges of iMON over a fixed window of iCLK cycles and flags
// out-of-range counts and a stuck input. Define CLK_FREQ_MONITOR_MINMAX_EN
// to track the min/max window count since the last enable.
module clk_freq_monitor
  import clk_mon_pkg::*;
#(
  parameter int GATE_CYCLES  = 1000,
  parameter int CNT_W        = 16,
  parameter int EXP_MIN      = 0,
  parameter int EXP_MAX      = 65535,
  parameter int STUCK_CYCLES = 256
) (
  input  logic             iCLK,
  input  logic             iRSTb,
  input  logic             iEN,
  input  logic             iMON,
  output logic [CNT_W-1:0] oCOUNT,
  output logic             oVALID,
  output logic             oIN_RANGE,
  output logic             oSTUCK,
  output logic [CNT_W-1:0] oMIN_COUNT,
  output logic [CNT_W-1:0] oMAX_COUNT
);

  localparam int FILL_W  = (FILL_CYCLES > 1) ? $clog2(FILL_CYCLES) : 1;
  localparam int GATE_W  = $clog2(GATE_CYCLES);
  localparam int STUCK_W = $clog2(STUCK_CYCLES + 1);

  localparam logic [FILL_W-1:0]  LP_FILL_LAST = FILL_W'(FILL_CYCLES - 1);
  localparam logic [GATE_W-1:0]  LP_GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [STUCK_W-1:0] LP_STUCK_MAX = STUCK_W'(STUCK_CYCLES);
  localparam logic [CNT_W-1:0]   LP_CNT_MAX   = '1;

  state_t             r_state;
  state_t             w_next;
  logic [FILL_W-1:0]  r_fill_cnt;
  logic [GATE_W-1:0]  r_gate_cnt;
  logic [CNT_W-1:0]   r_edge_cnt;
  logic [CNT_W-1:0]   w_edge_sum;
  logic [STUCK_W-1:0] r_stuck_cnt;
  logic [STUCK_W-1:0] w_stuck_nxt;
  logic [CNT_W-1:0]   r_count;
  logic               r_valid;
  logic               r_in_range;
  logic               r_stuck;
  logic               w_rise;
  logic               w_any;
  logic               w_terminal;

  sync_edge_detect u_sync (
    .iCLK  (iCLK),
    .iRSTb (iRSTb),
    .iIN   (iMON),
    .oRISE (w_rise),
    .oANY  (w_any)
  );

  assign w_terminal = (r_state == ST_GATE) && (r_gate_cnt == LP_GATE_LAST);

  // Includes the terminal cycle's strobe so no edge falls between windows.
  assign w_edge_sum = (r_edge_cnt == LP_CNT_MAX) ? r_edge_cnt
                                                 : r_edge_cnt + CNT_W'(w_rise);

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (iEN) w_next = ST_FILL;
      ST_FILL: begin
        if (!iEN)                           w_next = ST_IDLE;
        else if (r_fill_cnt == LP_FILL_LAST) w_next = ST_GATE;
      end
      ST_GATE: if (!iEN) w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_stuck_nxt = '0;
    if (r_state == ST_GATE && !w_any) begin
      w_stuck_nxt = (r_stuck_cnt == LP_STUCK_MAX) ? r_stuck_cnt
                                                  : r_stuck_cnt + STUCK_W'(1);
    end
  end

  always_ff @(posedge iCLK or negedge iRSTb) begin
    if (!iRSTb) begin
      r_state     <= ST_IDLE;
      r_fill_cnt  <= '0;
      r_gate_cnt  <= '0;
      r_edge_cnt  <= '0;
      r_stuck_cnt <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_in_range  <= 1'b0;
      r_stuck     <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_fill_cnt  <= (r_state == ST_FILL) ? r_fill_cnt + FILL_W'(1) : '0;
      r_gate_cnt  <= (r_state == ST_GATE && !w_terminal) ? r_gate_cnt + GATE_W'(1) : '0;
      r_edge_cnt  <= (r_state == ST_GATE && !w_terminal) ? w_edge_sum : '0;
      r_stuck_cnt <= w_stuck_nxt;
      r_stuck     <= (r_state == ST_GATE) && (r_stuck_cnt == LP_STUCK_MAX);
      r_valid     <= w_terminal;
      if (w_terminal) begin
        r_count    <= w_edge_sum;
        r_in_range <= in_window(32'(w_edge_sum), 32'(EXP_MIN), 32'(EXP_MAX));
      end
    end
  end

  assign oCOUNT    = r_count;
  assign oVALID    = r_valid;
  assign oIN_RANGE = r_in_range;
  assign oSTUCK    = r_stuck;

`ifdef CLK_FREQ_MONITOR_MINMAX_EN
  logic             w_start;
  logic             r_first;
  logic [CNT_W-1:0] r_min;
  logic [CNT_W-1:0] r_max;

  assign w_start = (r_state == ST_IDLE) && (w_next == ST_FILL);

  always_ff @(posedge iCLK or negedge iRSTb) begin
    if (!iRSTb) begin
      r_first <= 1'b0;
      r_min   <= '0;
      r_max   <= '0;
    end else if (w_start) begin
      r_first <= 1'b1;
    end else if (w_terminal) begin
      r_first <= 1'b0;
      if (r_first || (w_edge_sum < r_min)) r_min <= w_edge_sum;
      if (r_first || (w_edge_sum > r_max)) r_max <= w_edge_sum;
    end
  end

  assign oMIN_COUNT = r_min;
  assign oMAX_COUNT = r_max;
`else
  assign oMIN_COUNT = '0;
  assign oMAX_COUNT = '0;
`endif

endmodule

// File: tb/tb_clk_freq_monitor.sv
// Directed bench for clk_freq_monitor: nominal/out-of-range counts, abort,
// stuck detection, saturation (narrow instance) and asynchronous reset.
`timescale 1ns/100ps
module tb_clk_freq_monitor;

  logic        clk  = 1'b0;
  logic        rstb = 1'b0;
  logic        en1  = 1'b0;
  logic        en2  = 1'b0;
  logic        gmon1 = 1'b0;
  logic        gmon2 = 1'b0;
  logic        man_mode = 1'b0;
  logic        man_mon  = 1'b0;
  logic        mon1;
  logic        mon2;
  int          half1 = 0;
  int          half2 = 0;
  int          gcnt1 = 0;
  int          gcnt2 = 0;

  logic [15:0] count1, min1, max1;
  logic        v1, inr1, stk1;
  logic [3:0]  count2, min2, max2;
  logic        v2, inr2, stk2;

  int checks = 0;
  int errors = 0;

  assign mon1 = man_mode ? man_mon : gmon1;
  assign mon2 = gmon2;

  always #2.5 clk = ~clk;

  // Toggle generators: half period expressed in iCLK cycles (0 = frozen).
  always @(negedge clk) begin
    if (half1 != 0) begin
      gcnt1 = gcnt1 + 1;
      if (gcnt1 >= half1) begin gmon1 = ~gmon1; gcnt1 = 0; end
    end
    if (half2 != 0) begin
      gcnt2 = gcnt2 + 1;
      if (gcnt2 >= half2) begin gmon2 = ~gmon2; gcnt2 = 0; end
    end
  end

  clk_freq_monitor #(
    .GATE_CYCLES(1000), .CNT_W(16), .EXP_MIN(124), .EXP_MAX(126), .STUCK_CYCLES(256)
  ) dut (
    .iCLK(clk), .iRSTb(rstb), .iEN(en1), .iMON(mon1),
    .oCOUNT(count1), .oVALID(v1), .oIN_RANGE(inr1), .oSTUCK(stk1),
    .oMIN_COUNT(min1), .oMAX_COUNT(max1)
  );

  clk_freq_monitor #(
    .GATE_CYCLES(1000), .CNT_W(4), .EXP_MIN(0), .EXP_MAX(15), .STUCK_CYCLES(256)
  ) dut_sat (
    .iCLK(clk), .iRSTb(rstb), .iEN(en2), .iMON(mon2),
    .oCOUNT(count2), .oVALID(v2), .oIN_RANGE(inr2), .oSTUCK(stk2),
    .oMIN_COUNT(min2), .oMAX_COUNT(max2)
  );

  task automatic wait_valid(input bit which, input int budget,
                            output int lat, output bit timed_out);
    lat = 0;
    timed_out = 1'b1;
    while (timed_out && lat < budget) begin
      @(posedge clk); #1;
      lat++;
      if ((which ? v2 : v1) === 1'b1) timed_out = 1'b0;
    end
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (count1 !== 16'd0) begin errors++; $display("FAIL reset_count: actual %0d required 0", count1); end
    checks++; if ({v1, inr1, stk1} !== 3'b000) begin errors++; $display("FAIL reset_flags: actual %b required 000", {v1, inr1, stk1}); end
    checks++; if ({min1, max1} !== 32'd0) begin errors++; $display("FAIL reset_minmax: actual %0d/%0d required 0/0", min1, max1); end
    checks++; if ({count2, v2, inr2, stk2} !== 7'd0) begin errors++; $display("FAIL reset_sat: actual %b required 0", {count2, v2, inr2, stk2}); end
    @(negedge clk); rstb = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL idle_no_valid: actual %b required 0", v1); end
  endtask

  task automatic test_nominal();
    int lat; bit to;
    half1 = 4;
    @(negedge clk); en1 = 1'b1;
    wait_valid(0, 1100, lat, to);
    checks++; if (to || lat != 1003) begin errors++; $display("FAIL nominal_latency: actual %0d required 1003", lat); end
    checks++; if (count1 !== 16'd125) begin errors++; $display("FAIL nominal_count: actual %0d required 125", count1); end
    checks++; if (inr1 !== 1'b1) begin errors++; $display("FAIL nominal_in_range: actual %b required 1", inr1); end
    @(posedge clk); #1;
    checks++; if (v1 !== 1'b0) begin errors++; $display("FAIL valid_pulse_width: actual %b required 0", v1); end
    wait_valid(0, 1100, lat, to);
    checks++; if (to || lat != 999) begin errors++; $display("FAIL back_to_back_period: actual %0d required 999", lat); end
    checks++; if (count1 !== 16'd125) begin errors++; $display("FAIL nominal_count2: actual %0d required 125", count1); end
  endtask

  task automatic test_out_of_range();
    int lat; bit to;
    half1 = 5;
    wait_valid(0, 1100, lat, to);
    wait_valid(0, 1100, lat, to);
    checks++; if (to || count1 !== 16'd100) begin errors++; $display("FAIL oor_count: actual %0d required 100", count1); end
    checks++; if (inr1 !== 1'b0) begin errors++; $display("FAIL oor_in_range: actual %b required 0", inr1); end
  endtask

  task automatic test_minmax();
`ifdef CLK_FREQ_MONITOR_MINMAX_EN
    checks++; if (min1 !== 16'd100) begin errors++; $display("FAIL minmax_min: actual %0d required 100", min1); end
    checks++; if (max1 !== 16'd125) begin errors++; $display("FAIL minmax_max: actual %0d required 125", max1); end
`else
    checks++; if (min1 !== 16'd0) begin errors++; $display("FAIL minmax_min_off: actual %0d required 0", min1); end
    checks++; if (max1 !== 16'd0) begin errors++; $display("FAIL minmax_max_off: actual %0d required 0", max1); end
`endif
  endtask

  task automatic test_abort();
    int lat; bit to;
    repeat (500) @(posedge clk);
    @(negedge clk); en1 = 1'b0;
    wait_valid(0, 1100, lat, to);
    checks++; if (!to) begin errors++; $display("FAIL abort_no_valid: actual valid at %0d required none", lat); end
    checks++; if (count1 !== 16'd100) begin errors++; $display("FAIL abort_count_hold: actual %0d required 100", count1); end
    checks++; if (inr1 !== 1'b0 || stk1 !== 1'b0) begin errors++; $display("FAIL abort_flags: actual %b%b required 00", inr1, stk1); end
    @(negedge clk); en1 = 1'b1;
    wait_valid(0, 1100, lat, to);
    checks++; if (to || lat != 1003) begin errors++; $display("FAIL reenable_latency: actual %0d required 1003", lat); end
    checks++; if (count1 !== 16'd100) begin errors++; $display("FAIL reenable_count: actual %0d required 100", count1); end
  endtask

  task automatic test_stuck();
    @(negedge clk); man_mon = 1'b0; man_mode = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); man_mon = 1'b1;
      repeat (2) @(negedge clk);
      man_mon = 1'b0;
    end
    repeat (250) @(posedge clk);
    #1;
    checks++; if (stk1 !== 1'b0) begin errors++; $display("FAIL stuck_early: actual %b required 0", stk1); end
    repeat (10) @(posedge clk);
    #1;
    checks++; if (stk1 !== 1'b1) begin errors++; $display("FAIL stuck_assert: actual %b required 1", stk1); end
    @(negedge clk); man_mon = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (stk1 !== 1'b1) begin errors++; $display("FAIL stuck_hold_3: actual %b required 1", stk1); end
    @(posedge clk); #1;
    checks++; if (stk1 !== 1'b0) begin errors++; $display("FAIL stuck_release_4: actual %b required 0", stk1); end
    @(negedge clk); man_mode = 1'b0;
  endtask

  task automatic test_saturation();
    int lat; bit to;
    half2 = 2;
    @(negedge clk); en2 = 1'b1;
    wait_valid(1, 1100, lat, to);
    checks++; if (to || lat != 1003) begin errors++; $display("FAIL sat_latency: actual %0d required 1003", lat); end
    checks++; if (count2 !== 4'd15) begin errors++; $display("FAIL sat_count: actual %0d required 15", count2); end
    checks++; if (inr2 !== 1'b1) begin errors++; $display("FAIL sat_in_range: actual %b required 1", inr2); end
  endtask

  task automatic test_async_reset();
    int lat; bit to;
    half1 = 4;
    wait_valid(0, 1100, lat, to);
    wait_valid(0, 1100, lat, to);
    checks++; if (to || count1 !== 16'd125) begin errors++; $display("FAIL pre_reset_count: actual %0d required 125", count1); end
    repeat (300) @(posedge clk);
    #1; rstb = 1'b0;
    #0.5;
    checks++; if (count1 !== 16'd0) begin errors++; $display("FAIL async_count: actual %0d required 0", count1); end
    checks++; if ({v1, inr1, stk1} !== 3'b000) begin errors++; $display("FAIL async_flags: actual %b required 000", {v1, inr1, stk1}); end
    checks++; if ({min1, max1} !== 32'd0) begin errors++; $display("FAIL async_minmax: actual %0d/%0d required 0/0", min1, max1); end
    checks++; if (count2 !== 4'd0) begin errors++; $display("FAIL async_sat_count: actual %0d required 0", count2); end
    @(negedge clk); rstb = 1'b1;
    wait_valid(0, 1100, lat, to);
    checks++; if (to || lat != 1003) begin errors++; $display("FAIL post_reset_latency: actual %0d required 1003", lat); end
    checks++; if (count1 !== 16'd125) begin errors++; $display("FAIL post_reset_count: actual %0d required 125", count1); end
`ifdef CLK_FREQ_MONITOR_MINMAX_EN
    checks++; if (min1 !== 16'd125 || max1 !== 16'd125) begin errors++; $display("FAIL post_reset_minmax: actual %0d/%0d required 125/125", min1, max1); end
`endif
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_out_of_range();
    test_minmax();
    test_abort();
    test_stuck();
    test_saturation();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
